// File: rtl/block_serial_div.sv
// Restartable restoring divider for the HI/LO unit: one quotient bit per clock,
// magnitudes first, sign fix-up in a final cycle, results qualified by a one-cycle ready.
module block_serial_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   dividend,
    input  logic [WIDTH:0]   divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // state | meaning
    // IDLE  | waiting for start; results held
    // ITER  | one restoring step per cycle, WIDTH cycles
    // FIX   | apply operand signs, register results, ready next cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;

    // Low WIDTH bits of the two's-complement negation are the magnitude, including -2^WIDTH-1.
    assign dividend_mag = dividend[WIDTH] ? (~dividend[WIDTH-1:0] + 1'b1) : dividend[WIDTH-1:0];
    assign divisor_mag  = divisor[WIDTH]  ? (~divisor[WIDTH-1:0]  + 1'b1) : divisor[WIDTH-1:0];

    // The partial remainder plus the incoming bit needs one extra bit; the kept
    // difference is always below the divisor, so only its low WIDTH bits are stored.
    assign shifted    = {prem_q, dvd_q[WIDTH-1]};
    assign trial_ge   = (shifted >= {1'b0, dvs_q});
    assign trial_diff = shifted[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        rdy_d   = 1'b0;

        case (state_q)
            S_ITER: begin
                // dvd_q shifts out dividend bits and shifts in quotient bits
                prem_d = trial_ge ? trial_diff : shifted[WIDTH-1:0];
                dvd_d  = {dvd_q[WIDTH-2:0], trial_ge};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d   = (sa_q ^ sb_q) ? (~dvd_q + 1'b1) : dvd_q;
                rem_d   = sa_q ? (~prem_q + 1'b1) : prem_q;
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
            end
        endcase

        // A new request always wins; an aborted division must not publish results.
        if (start) begin
            state_d = S_ITER;
            cnt_d   = CNT_INIT;
            sa_d    = dividend[WIDTH];
            sb_d    = divisor[WIDTH];
            dvd_d   = dividend_mag;
            dvs_d   = divisor_mag;
            prem_d  = '0;
            quo_d   = quo_q;
            rem_d   = rem_q;
            rdy_d   = 1'b0;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ready     = rdy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_block_serial_div.sv
// Self-checking bench for block_serial_div: directed corner cases plus random
// operands compared against a plain-arithmetic reference.
module tb_block_serial_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [32:0] dividend;
    logic [32:0] divisor;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    block_serial_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    // Reference: 33-bit two's-complement operands, C-style truncating division.
    function automatic void ref_div(input logic [32:0] a, input logic [32:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint av, bv, qq, rr;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        if (bv == 0) begin
            q = a[32] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a[31:0];
        end else begin
            qq = av / bv;
            rr = av % bv;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    function automatic logic [32:0] rnd_op(input bit sgn, input int shift);
        logic [31:0] x;
        x = $urandom >> shift;
        if (sgn && $urandom_range(0, 1) == 1) x = -x;
        return sgn ? {x[31], x} : {1'b0, x};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [32:0] a, input logic [32:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
    endtask

    // Returns the cycle (start cycle = 0) in which ready was seen; 60 means it never came.
    task automatic wait_ready(output int cyc, output bit busy_ok);
        cyc     = 1;
        busy_ok = 1'b1;
        while (ready !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_r got=%h exp=0", remainder); end
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy=%b ready=%b exp=0/0", busy, ready); end
    endtask

    task automatic test_unsigned_basic();
        int cyc; bit bok;
        start_op(33'h0_0000_0064, 33'h0_0000_0007);
        wait_ready(cyc, bok);
        checks++; if (cyc != 34) begin errors++; $display("FAIL u100_7_latency got=%0d exp=34", cyc); end
        checks++; if (!bok) begin errors++; $display("FAIL u100_7_busy got=bad exp=high 1..33 low 34"); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL u100_7_q got=%h exp=%h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL u100_7_r got=%h exp=%h", remainder, 32'd2); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got=%b exp=0", ready); end
    endtask

    task automatic test_directed();
        logic [32:0] a_tab [6] = '{33'h1_FFFF_FFF9, 33'h0_0000_0007, 33'h0_1234_5678,
                                   33'h1_FFFF_FFF0, 33'h1_8000_0000, 33'h0_FFFF_FFFF};
        logic [32:0] b_tab [6] = '{33'h0_0000_0002, 33'h1_FFFF_FFFE, 33'h0_0000_0000,
                                   33'h0_0000_0000, 33'h1_FFFF_FFFF, 33'h0_0000_0001};
        logic [31:0] q_tab [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] r_tab [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678,
                                   32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000};
        int cyc; bit bok;
        for (int i = 0; i < 6; i++) begin
            start_op(a_tab[i], b_tab[i]);
            wait_ready(cyc, bok);
            checks++; if (cyc != 34) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=34", i, cyc); end
            checks++; if (quotient !== q_tab[i]) begin errors++; $display("FAIL dir%0d_q got=%h exp=%h", i, quotient, q_tab[i]); end
            checks++; if (remainder !== r_tab[i]) begin errors++; $display("FAIL dir%0d_r got=%h exp=%h", i, remainder, r_tab[i]); end
            step();
        end
    endtask

    task automatic test_random();
        logic [32:0] a, b;
        logic [31:0] eq, er;
        int cyc; bit bok, sgn;
        for (int i = 0; i < 40; i++) begin
            sgn = bit'($urandom_range(0, 1));
            a   = rnd_op(sgn, $urandom_range(0, 8));
            b   = rnd_op(sgn, $urandom_range(0, 31));
            ref_div(a, b, eq, er);
            start_op(a, b);
            wait_ready(cyc, bok);
            checks++; if (cyc != 34 || !bok) begin errors++; $display("FAIL rnd%0d_timing got=%0d busy_ok=%b exp=34/1", i, cyc, bok); end
            checks++; if (quotient !== eq || remainder !== er) begin
                errors++; $display("FAIL rnd%0d_result a=%h b=%h got=%h/%h exp=%h/%h", i, a, b, quotient, remainder, eq, er);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_restart();
        int cyc; bit bok, early;
        start_op(33'h0_0000_0064, 33'h0_0000_0007);
        early = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (ready !== 1'b0) early = 1'b1;
            step();
        end
        start_op(33'h0_0000_0032, 33'h0_0000_0005);
        wait_ready(cyc, bok);
        checks++; if (early) begin errors++; $display("FAIL restart_early_ready got=1 exp=0"); end
        checks++; if (cyc != 34) begin errors++; $display("FAIL restart_latency got=%0d exp=34 (abs 44)", cyc); end
        checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin errors++; $display("FAIL restart_result got=%h/%h exp=%h/%h", quotient, remainder, 32'd10, 32'd0); end
        step();
        // Restart landing on the FIX cycle
        start_op(33'h0_0000_0064, 33'h0_0000_0007);
        for (int i = 0; i < 32; i++) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_cycle_busy got=%b exp=1", busy); end
        start_op(33'h0_0000_0009, 33'h0_0000_0004);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fix_abort_ready got=%b exp=0", ready); end
        wait_ready(cyc, bok);
        checks++; if (cyc != 34) begin errors++; $display("FAIL fix_restart_latency got=%0d exp=34", cyc); end
        checks++; if (quotient !== 32'd2 || remainder !== 32'd1) begin errors++; $display("FAIL fix_restart_result got=%h/%h exp=%h/%h", quotient, remainder, 32'd2, 32'd1); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit bok;
        // Called while ready is high from the previous task: start in the ready cycle.
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before got=%b exp=1", ready); end
        start_op(33'h1_FFFF_FF9C, 33'h0_0000_0003);
        checks++; if (quotient !== 32'd2 || remainder !== 32'd1) begin errors++; $display("FAIL b2b_hold_on_start got=%h/%h exp=%h/%h", quotient, remainder, 32'd2, 32'd1); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (quotient !== 32'd2 || busy !== 1'b1) begin errors++; $display("FAIL b2b_hold_mid got=%h busy=%b exp=%h busy=1", quotient, busy, 32'd2); end
        wait_ready(cyc, bok);
        checks++; if (cyc != 30) begin errors++; $display("FAIL b2b_latency got=%0d exp=30 after 4 skipped", cyc); end
        checks++; if (quotient !== 32'hFFFF_FFDF || remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", quotient, remainder, 32'hFFFF_FFDF, 32'hFFFF_FFFF); end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc, stray; bit bok;
        start_op(33'h0_0000_0064, 33'h0_0000_0007);
        for (int i = 0; i < 19; i++) step();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl busy=%b ready=%b exp=0/0", busy, ready); end
        checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin errors++; $display("FAIL rst_mid_out got=%h/%h exp=0/0", quotient, remainder); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray got=%0d exp=0", stray); end
        start_op(33'h0_0000_03E8, 33'h0_0000_0021);
        wait_ready(cyc, bok);
        checks++; if (cyc != 34 || !bok) begin errors++; $display("FAIL rst_fresh_timing got=%0d busy_ok=%b exp=34/1", cyc, bok); end
        checks++; if (quotient !== 32'd30 || remainder !== 32'd10) begin errors++; $display("FAIL rst_fresh_result got=%h/%h exp=%h/%h", quotient, remainder, 32'd30, 32'd10); end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_directed();
        test_random();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_serial_div.md
Name: block_serial_div

Overview:
- Fixed-latency restart-able sequential divider for the R3000 HI/LO unit.
- Takes 33-bit pre-extended operands from the issue logic.
- Produces quotient and remainder with a one-cycle ready pulse, which the multiply/divide block samples into LO and HI.
- Computes one quotient bit per clock using restoring division on operand magnitudes, then applies a sign fix-up.

Parameters:
- WIDTH, 32, operand/result magnitude width. Latency is WIDTH+2 cycles. Only 32 is verified.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; operands are sampled in the same cycle.
- dividend  in  WIDTH+1  bit WIDTH is the sign extension; the caller sets it to 0 for DIVU.
- divisor  in  WIDTH+1  same extension rule as dividend.
- busy  out  1  high while a division is in flight (ITER or FIX state).
- ready  out  1  single-cycle pulse; the results are valid in the same cycle.
- quotient  out  WIDTH  low WIDTH bits of the signed/unsigned quotient.
- remainder  out  WIDTH  remainder; it carries the dividend's sign.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, ready=0, quotient=0, remainder=0, counter=0. Reset mid-operation aborts it; no ready pulse follows.
- Operation is signed iff the operand bit WIDTH is 1 (two's-complement on WIDTH+1 bits).
- On start: latch sa=dividend[WIDTH], sb=divisor[WIDTH], |dividend| and |divisor| (WIDTH bits each). Clear the partial remainder (WIDTH+1 bits) and set counter=WIDTH.
- States: IDLE -> ITER on start. ITER -> FIX when counter reaches 0 after the last iteration. FIX -> IDLE unconditionally.
- ITER, each cycle:
  - Shift in the next dividend MSB.
  - Trial-subtract |divisor|. If non-negative, keep the difference and set quotient bit=1; else restore and set bit=0.
  - Decrement counter. Exactly WIDTH ITER cycles.
- FIX:
  - quotient = (sa^sb) ? -Qmag : Qmag.
  - remainder = sa ? -Rmag : Rmag.
  - Truncate both to WIDTH bits, register them, and assert ready for the next cycle.
- Timing: start in cycle 0 -> ITER cycles 1..32 -> FIX cycle 33 -> ready=1 in cycle 34 only.
  - busy=1 in cycles 1..33; busy=0 in cycle 34 (IDLE).
- ready is deasserted on every cycle other than the one following FIX.
- quotient/remainder hold their values until the next ready. They are not cleared by a new start.
- Divide by zero needs no special path; restoring division yields Qmag=all ones, Rmag=|dividend|. Results:
  - unsigned: q=0xFFFFFFFF, r=dividend.
  - signed, dividend>=0: q=0xFFFFFFFF.
  - signed, dividend<0: q=0x00000001, r=dividend.
  - Latency is unchanged.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0. Truncation, no trap.
- start while busy (including the FIX cycle): abort the current division, resample the operands, restart from cycle 0 timing. The aborted division produces no ready.
- start in the same cycle ready is high is legal. The ready pulse is still delivered and the new operation begins.
- start together with rst: rst wins.

Test Plan:
- Unsigned 100 / 7 (dividend=0x0_00000064, divisor=0x0_00000007): ready exactly 34 cycles after start, q=14, r=2, busy high for cycles 1..33.
- Signed -7 / 2 (0x1_FFFFFFF9, 0x0_00000002): q=0xFFFFFFFD, r=0xFFFFFFFF. Then signed 7 / -2: q=0xFFFFFFFD, r=0x00000001.
- Divide by zero:
  - unsigned 0x12345678/0: q=0xFFFFFFFF, r=0x12345678.
  - signed 0xFFFFFFF0/0: q=0x00000001, r=0xFFFFFFF0.
  - Both after 34 cycles.
- Overflow: 0x1_80000000 / 0x1_FFFFFFFF gives q=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 gives q=0xFFFFFFFF, r=0.
- Restart: start 100/7, then a second start with 50/5 at cycle 10. No ready at cycle 34; a single ready at cycle 44 with q=10, r=0.
- Reset mid-op: assert rst at cycle 20 of a division. Outputs go to 0 asynchronously, busy=0, no ready thereafter. A fresh start after release completes normally.
